// File: rtl/gptp_pkg.sv
// gptp_pkg: shared gPTP constants, frame layout offsets and initiator state type.
// Frame byte k lives at bits [351-8k -: 8]; unlisted bytes are zero.
package gptp_pkg;

  localparam logic [3:0]  PDELAY_REQ         = 4'h2;
  localparam logic [3:0]  PDELAY_RESP        = 4'h3;
  localparam logic [3:0]  TRANSPORT_SPECIFIC = 4'h1;
  localparam logic [7:0]  PTP_VERSION        = 8'h02;
  localparam logic [15:0] PDELAY_REQ_LEN     = 16'd44;
  localparam logic [7:0]  CONTROL_OTHER      = 8'h05;
  localparam logic [7:0]  LOG_MSG_INTERVAL   = 8'h7F;

  localparam int unsigned FRAME_W = 352;

  // 80-bit timestamp: {epoch16, sec32, ns32}
  localparam int unsigned TS_EPOCH_W = 16;
  localparam int unsigned TS_SEC_W   = 32;
  localparam int unsigned TS_NS_W    = 32;
  localparam int unsigned TS_W       = TS_EPOCH_W + TS_SEC_W + TS_NS_W;
  localparam int unsigned RX_W       = TS_W + FRAME_W;

  // Header field LSB offsets inside the 352-bit frame
  localparam int unsigned TSPEC_LSB   = 348;
  localparam int unsigned MSGTYPE_LSB = 344;
  localparam int unsigned VERSION_LSB = 336;
  localparam int unsigned LEN_LSB     = 320;
  localparam int unsigned SRCPORT_LSB = 112;
  localparam int unsigned SEQ_LSB     = 96;
  localparam int unsigned CTRL_LSB    = 88;
  localparam int unsigned LOGINT_LSB  = 80;
  localparam int unsigned BODYTS_LSB  = 0;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_PERIOD,
    SEND,
    WAIT_TS,
    WAIT_RESP
  } state_e;

  // Assemble a Pdelay_Req frame; originTimestamp stays zero.
  function automatic logic [FRAME_W-1:0] build_pdelay_req(
    input logic [TS_W-1:0] src_port,
    input logic [15:0]     seq
  );
    logic [FRAME_W-1:0] f;
    f = '0;
    f[TSPEC_LSB   +: 4]    = TRANSPORT_SPECIFIC;
    f[MSGTYPE_LSB +: 4]    = PDELAY_REQ;
    f[VERSION_LSB +: 8]    = PTP_VERSION;
    f[LEN_LSB     +: 16]   = PDELAY_REQ_LEN;
    f[SRCPORT_LSB +: TS_W] = src_port;
    f[SEQ_LSB     +: 16]   = seq;
    f[CTRL_LSB    +: 8]    = CONTROL_OTHER;
    f[LOGINT_LSB  +: 8]    = LOG_MSG_INTERVAL;
    return f;
  endfunction

endpackage

// File: rtl/gptp_ts_diff.sv
// gptp_ts_diff: nanosecond difference t_end - t_start between two 80-bit gPTP
// timestamps. Valid only when {epoch,sec} are equal or t_end is exactly one
// second later; any other relation (including t_end < t_start) yields all-ones.
module gptp_ts_diff
  import gptp_pkg::*;
(
  input  logic [TS_W-1:0]    t_start_i,
  input  logic [TS_W-1:0]    t_end_i,
  output logic [TS_NS_W-1:0] diff_ns_o
);

  logic [TS_EPOCH_W+TS_SEC_W-1:0] es_start, es_end;
  logic [TS_NS_W-1:0]             ns_start, ns_end;
  logic [TS_NS_W:0]               end_plus_sec;
  logic [TS_NS_W:0]               wrap_diff;

  // Select the same-second or one-second-carry difference, else saturate
  always_comb begin
    es_start     = t_start_i[TS_W-1:TS_NS_W];
    es_end       = t_end_i[TS_W-1:TS_NS_W];
    ns_start     = t_start_i[TS_NS_W-1:0];
    ns_end       = t_end_i[TS_NS_W-1:0];
    end_plus_sec = {1'b0, ns_end} + 33'd1_000_000_000;
    wrap_diff    = end_plus_sec - {1'b0, ns_start};
    diff_ns_o    = '1;
    if (es_end == es_start) begin
      if (ns_end >= ns_start) diff_ns_o = ns_end - ns_start;
    end else if (es_end == es_start + 48'd1) begin
      if ((end_plus_sec >= {1'b0, ns_start}) && !wrap_diff[TS_NS_W])
        diff_ns_o = wrap_diff[TS_NS_W-1:0];
    end
  end

endmodule

// File: rtl/gptp_pdelay_initiator.sv
// gptp_pdelay_initiator: periodic gPTP peer-delay request initiator.
// Sends Pdelay_Req, captures t1 from the tx timestamp strobe, matches the
// Pdelay_Resp by sequenceId and reports t2/t4, or pulses timeout.
// Optional build macro GPTP_PDELAY_RTT_EN adds rtt_ns (t4.ns - t1.ns).
module gptp_pdelay_initiator
  import gptp_pkg::*;
#(
  parameter logic [31:0] PERIOD  = 32'd1000,
  parameter logic [31:0] TIMEOUT = 32'd5000
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic [79:0]  src_port_id,
  output logic         gptp_ts_vaild,
  input  logic         gptp_ts_ready,
  output logic [351:0] gptp_ts_data,
  input  logic         gptp_ts_rv_vaild,
  input  logic [79:0]  gptp_ts_rv_data,
  input  logic [431:0] gptp_rv_data,
  input  logic         gptp_rv_vaild,
  output logic         gptp_rv_ready,
  output logic [79:0]  t1,
  output logic [79:0]  t2,
  output logic [79:0]  t4,
  output logic         result_vaild,
  output logic         timeout,
  output logic [15:0]  seq_id,
  output logic [15:0]  drop_cnt
`ifdef GPTP_PDELAY_RTT_EN
  ,
  output logic [31:0]  rtt_ns
`endif
);

  state_e      state_q, state_d;
  logic [15:0] seq_q, seq_d;
  logic [15:0] drop_q, drop_d;
  logic [79:0] t1_q, t1_d, t2_q, t2_d, t4_q, t4_d;
  logic [31:0] period_cnt_q, period_cnt_d;
  logic [31:0] to_cnt_q, to_cnt_d;
  logic        result_q, result_d;
  logic        timeout_q, timeout_d;
  logic        rv_ready_q;

  logic        ts_accept, rx_xfer, rx_match, to_expire, period_done;
  logic        waiting_q, waiting_d;
  logic [79:0] rx_ts, rx_body_ts;
  logic [3:0]  rx_type;
  logic [15:0] rx_seq;
  logic        unused_rx_bits;

  assign unused_rx_bits = ^{gptp_rv_data[351:348], gptp_rv_data[343:112],
                            gptp_rv_data[95:80]};

  // Decode the receive word and the handshake/timer events used by the FSM
  always_comb begin
    rx_ts       = gptp_rv_data[RX_W-1:FRAME_W];
    rx_type     = gptp_rv_data[MSGTYPE_LSB +: 4];
    rx_seq      = gptp_rv_data[SEQ_LSB +: 16];
    rx_body_ts  = gptp_rv_data[BODYTS_LSB +: TS_W];
    ts_accept   = (state_q == SEND) && gptp_ts_ready;
    rx_xfer     = gptp_rv_vaild && rv_ready_q;
    rx_match    = rx_xfer && (state_q == WAIT_RESP) && (rx_type == PDELAY_RESP) &&
                  (rx_seq == seq_q - 16'd1);
    waiting_q   = (state_q == WAIT_TS) || (state_q == WAIT_RESP);
    to_expire   = waiting_q && (to_cnt_q == TIMEOUT - 32'd1);
    period_done = (state_q == WAIT_PERIOD) && (period_cnt_q == PERIOD - 32'd1);
  end

  // State register
  always_ff @(posedge clk) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic; a match on the expiry cycle takes the same exit as timeout
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:        if (enable) state_d = SEND;
      WAIT_PERIOD: if (period_done) state_d = enable ? SEND : IDLE;
      SEND:        if (ts_accept) state_d = WAIT_TS;
      WAIT_TS: begin
        if (to_expire)             state_d = WAIT_PERIOD;
        else if (gptp_ts_rv_vaild) state_d = WAIT_RESP;
      end
      WAIT_RESP:   if (rx_match || to_expire) state_d = WAIT_PERIOD;
      default:     state_d = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    gptp_ts_vaild = (state_q == SEND);
    gptp_ts_data  = build_pdelay_req(src_port_id, seq_q);
  end

  // Datapath next values: counters, latched timestamps and one-cycle pulses
  always_comb begin
    waiting_d    = (state_d == WAIT_TS) || (state_d == WAIT_RESP);
    seq_d        = ts_accept ? seq_q + 16'd1 : seq_q;
    period_cnt_d = (state_q == WAIT_PERIOD && !period_done) ? period_cnt_q + 32'd1 : '0;
    to_cnt_d     = (waiting_q && waiting_d) ? to_cnt_q + 32'd1 : '0;
    t1_d         = t1_q;
    t2_d         = t2_q;
    t4_d         = t4_q;
    result_d     = 1'b0;
    timeout_d    = to_expire && !rx_match;
    drop_d       = drop_q;
    if ((state_q == WAIT_TS) && gptp_ts_rv_vaild && !to_expire) t1_d = gptp_ts_rv_data;
    if (rx_match) begin
      t4_d     = rx_ts;
      t2_d     = rx_body_ts;
      result_d = 1'b1;
    end
    if (rx_xfer && !rx_match && (drop_q != '1)) drop_d = drop_q + 16'd1;
  end

  // Datapath registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      seq_q        <= '0;
      drop_q       <= '0;
      t1_q         <= '0;
      t2_q         <= '0;
      t4_q         <= '0;
      period_cnt_q <= '0;
      to_cnt_q     <= '0;
      result_q     <= 1'b0;
      timeout_q    <= 1'b0;
      rv_ready_q   <= 1'b0;
    end else begin
      seq_q        <= seq_d;
      drop_q       <= drop_d;
      t1_q         <= t1_d;
      t2_q         <= t2_d;
      t4_q         <= t4_d;
      period_cnt_q <= period_cnt_d;
      to_cnt_q     <= to_cnt_d;
      result_q     <= result_d;
      timeout_q    <= timeout_d;
      rv_ready_q   <= 1'b1;
    end
  end

  assign gptp_rv_ready = rv_ready_q;
  assign t1            = t1_q;
  assign t2            = t2_q;
  assign t4            = t4_q;
  assign result_vaild  = result_q;
  assign timeout       = timeout_q;
  assign seq_id        = seq_q;
  assign drop_cnt      = drop_q;

`ifdef GPTP_PDELAY_RTT_EN
  logic [31:0] rtt_q, rtt_d, rtt_calc;

  // t4 is taken straight from the rx word so rtt loads on the same edge as t4
  gptp_ts_diff u_ts_diff (
    .t_start_i (t1_q),
    .t_end_i   (rx_ts),
    .diff_ns_o (rtt_calc)
  );

  // Next rtt value: refreshed only on a matched response
  always_comb begin
    rtt_d = rx_match ? rtt_calc : rtt_q;
  end

  // rtt register
  always_ff @(posedge clk) begin
    if (!reset) rtt_q <= '0;
    else        rtt_q <= rtt_d;
  end

  assign rtt_ns = rtt_q;
`endif

endmodule
